// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundle of the requester-side and output-side signals of mux4_rr_arbiter.
//   req       : per-requester word-valid flags
//   in_data   : four packed W-bit lanes, lane i at in_data[i*W +: W]
//   gnt       : one-hot capture strobe back to the requesters
//   sel       : current owner index (registered mux select)
//   out_data  : registered output word
//   out_valid : out_data holds an unconsumed word
//   out_ready : downstream accepts out_data this cycle
//   busy      : arbiter is inside a grant
// slave  = arbiter side, master = environment side.
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
  parameter int W = 2
) ();
  logic [3:0]     req;
  logic [4*W-1:0] in_data;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport slave (
    input  req, in_data, out_ready,
    output gnt, sel, out_data, out_valid, busy
  );

  modport master (
    output req, in_data, out_ready,
    input  gnt, sel, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin owner selection for a shared 4:1 word mux feeding one
// registered valid/ready output stage. An owner keeps the mux for at most
// BURST captured words, then arbitration passes on through one IDLE cycle.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux4_rr_arbiter_if.slave (req/in_data/gnt/sel/out_* /busy)
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int W     = 2,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_rr_arbiter_if.slave      bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [4:0] BEAT_LAST = 5'(BURST - 1);

  state_t       state_q,     state_d;
  logic [1:0]   sel_q,       sel_d;
  logic [1:0]   last_q,      last_d;
  logic [4:0]   beat_cnt_q,  beat_cnt_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         out_valid_q, out_valid_d;

  logic [W-1:0] lane_word;
  logic         free;
  logic         capture;

  // First requester after 'last' in circular order. Offsets are walked from
  // farthest to nearest so the nearest hit is the one that sticks.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    case (sel_q)
      2'd0:    lane_word = bus.in_data[0*W +: W];
      2'd1:    lane_word = bus.in_data[1*W +: W];
      2'd2:    lane_word = bus.in_data[2*W +: W];
      default: lane_word = bus.in_data[3*W +: W];
    endcase
  end

  assign free    = !out_valid_q || bus.out_ready;
  assign capture = (state_q == GRANT) && bus.req[sel_q] && free;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Output stage: a capture overwrites (and thereby consumes) the old word;
    // otherwise a ready downstream drains it and the data value is kept.
    if (capture) begin
      out_data_d  = lane_word;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (|bus.req) begin
        sel_d      = rr_pick(bus.req, last_q);
        beat_cnt_d = 5'd0;
        state_d    = GRANT;
      end
    end else begin
      // Withdrawal releases the grant even while the output is stalled.
      if (!bus.req[sel_q]) begin
        last_d  = sel_q;
        state_d = IDLE;
      end else if (free) begin
        if (beat_cnt_q == BEAT_LAST) begin
          last_d     = sel_q;
          beat_cnt_d = 5'd0;
          state_d    = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + 5'd1;
        end
      end
    end
  end

  // last resets to 3 so the first scan starts at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      last_q      <= 2'd3;
      beat_cnt_q  <= 5'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      beat_cnt_q  <= beat_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.gnt       = capture ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed bench for mux4_rr_arbiter. Instance A uses BURST=4, instance B
// uses BURST=1, both with 8-bit lanes. Expected output words are queued when
// each scenario starts; per-instance monitors pop and compare on every
// accepted transfer. Cycle-exact control checks run in the main process.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.W(8)) a_if ();
  mux4_rr_arbiter_if #(.W(8)) b_if ();

  mux4_rr_arbiter #(.W(8), .BURST(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  mux4_rr_arbiter #(.W(8), .BURST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  logic [7:0] lane_a [4];
  logic [7:0] lane_b [4];
  logic [3:0] adv_a, adv_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: one pop per accepted output word.
  always @(negedge clk) begin
    if (rst_n && a_if.out_valid && a_if.out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_word actual=%0h required=none", a_if.out_data);
      end else begin
        chk("a_out_data", 32'(a_if.out_data), 32'(qa.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_if.out_valid && b_if.out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_word actual=%0h required=none", b_if.out_data);
      end else begin
        chk("b_out_data", 32'(b_if.out_data), 32'(qb.pop_front()));
      end
    end
  end

  task automatic drive();
    a_if.in_data = {lane_a[3], lane_a[2], lane_a[1], lane_a[0]};
    b_if.in_data = {lane_b[3], lane_b[2], lane_b[1], lane_b[0]};
  endtask

  // One clock: gnt is sampled mid-cycle, and requesters that were granted
  // present their next word just after the capturing edge.
  task automatic tick();
    logic [3:0] ga, gb;
    @(negedge clk);
    ga = a_if.gnt;
    gb = b_if.gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ga[i] && adv_a[i]) lane_a[i] = lane_a[i] + 8'd1;
      if (gb[i] && adv_b[i]) lane_b[i] = lane_b[i] + 8'd1;
    end
    drive();
  endtask

  task automatic wait_busy_a(input logic want);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (a_if.busy !== want && n < 20);
    chk("a_wait_busy", 32'(a_if.busy), 32'(want));
  endtask

  task automatic push_run_a(input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) qa.push_back(first + 8'(i));
  endtask

  task automatic idle_gap();
    a_if.req = 4'b0000;
    b_if.req = 4'b0000;
    drive();
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      lane_a[i] = 8'h00;
      lane_b[i] = 8'h00;
    end
    adv_a = 4'b0000;
    adv_b = 4'b0000;
    a_if.req = 4'b0000;
    b_if.req = 4'b0000;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    drive();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(a_if.out_valid), 32'h0);
    chk("rst_out_data",  32'(a_if.out_data),  32'h0);
    chk("rst_sel",       32'(a_if.sel),       32'h0);
    chk("rst_gnt",       32'(a_if.gnt),       32'h0);
    chk("rst_busy",      32'(a_if.busy),      32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) tick();

    // Burst cap: one owner, six words, split 4 + 2 by an IDLE bubble.
    push_run_a(8'h10, 6);
    lane_a[0] = 8'h10; adv_a = 4'b0001; a_if.req = 4'b0001; drive();
    tick();
    chk("t1_busy_grant", 32'(a_if.busy), 32'h1);
    chk("t1_sel",        32'(a_if.sel),  32'h0);
    chk("t1_gnt_beat0",  32'(a_if.gnt),  32'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_gnt_beat", 32'(a_if.gnt), 32'h1);
    end
    tick();
    chk("t1_bubble_busy", 32'(a_if.busy),     32'h0);
    chk("t1_bubble_gnt",  32'(a_if.gnt),      32'h0);
    chk("t1_bubble_data", 32'(a_if.out_data), 32'h13);
    tick();
    chk("t1_regrant_busy", 32'(a_if.busy), 32'h1);
    for (int n = 0; n < 10 && lane_a[0] != 8'h16; n++) tick();
    chk("t1_lane_done", 32'(lane_a[0]), 32'h16);
    a_if.req = 4'b0000; drive();
    #1 chk("t1_release_gnt", 32'(a_if.gnt), 32'h0);
    tick();
    chk("t1_release_busy", 32'(a_if.busy), 32'h0);
    idle_gap();

    // BURST=1 rotation across four constant lanes.
    lane_b[0] = 8'h00; lane_b[1] = 8'h55; lane_b[2] = 8'hAA; lane_b[3] = 8'hFF;
    qb.push_back(8'h00); qb.push_back(8'h55); qb.push_back(8'hAA);
    qb.push_back(8'hFF); qb.push_back(8'h00); qb.push_back(8'h55);
    b_if.req = 4'b1111; drive();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2_sel",       32'(b_if.sel),  32'(k % 4));
      chk("t2_busy",      32'(b_if.busy), 32'h1);
      tick();
      chk("t2_bubble",    32'(b_if.busy), 32'h0);
    end
    idle_gap();

    // Backpressure: five stalled cycles after the first capture.
    push_run_a(8'h10, 4);
    lane_a[0] = 8'h10; adv_a = 4'b0001; a_if.req = 4'b0001; a_if.out_ready = 1'b1; drive();
    tick();
    a_if.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_valid", 32'(a_if.out_valid), 32'h1);
      chk("t3_stall_data",  32'(a_if.out_data),  32'h10);
      chk("t3_stall_gnt",   32'(a_if.gnt),       32'h0);
      chk("t3_stall_busy",  32'(a_if.busy),      32'h1);
      chk("t3_stall_sel",   32'(a_if.sel),       32'h0);
    end
    a_if.out_ready = 1'b1;
    #1 chk("t3_resume_gnt", 32'(a_if.gnt), 32'h1);
    tick();
    tick();
    chk("t3_mid_busy", 32'(a_if.busy), 32'h1);
    tick();
    chk("t3_end_busy", 32'(a_if.busy),     32'h0);
    chk("t3_end_data", 32'(a_if.out_data), 32'h13);
    idle_gap();

    // Fairness between requesters 1 and 3.
    push_run_a(8'h30, 4);
    push_run_a(8'h40, 4);
    push_run_a(8'h34, 4);
    lane_a[3] = 8'h30; adv_a = 4'b1010; a_if.req = 4'b1000; drive();
    wait_busy_a(1'b1);
    chk("t4_sel_first3", 32'(a_if.sel), 32'h3);
    wait_busy_a(1'b0);
    lane_a[1] = 8'h40; a_if.req = 4'b1010; drive();
    wait_busy_a(1'b1);
    chk("t4_sel_1", 32'(a_if.sel), 32'h1);
    wait_busy_a(1'b0);
    wait_busy_a(1'b1);
    chk("t4_sel_3", 32'(a_if.sel), 32'h3);
    wait_busy_a(1'b0);
    wait_busy_a(1'b1);
    chk("t4_sel_1_again", 32'(a_if.sel), 32'h1);
    a_if.req = 4'b0000; drive();
    wait_busy_a(1'b0);
    idle_gap();

    // Owner 2 withdraws after two beats while requester 0 waits.
    qa.push_back(8'h20); qa.push_back(8'h21);
    push_run_a(8'h50, 4);
    lane_a[2] = 8'h20; lane_a[0] = 8'h50; adv_a = 4'b0101; a_if.req = 4'b0101; drive();
    wait_busy_a(1'b1);
    chk("t5_sel_2", 32'(a_if.sel), 32'h2);
    tick();
    tick();
    chk("t5_two_beats", 32'(lane_a[2]), 32'h22);
    a_if.req = 4'b0001; drive();
    #1 chk("t5_withdraw_gnt", 32'(a_if.gnt), 32'h0);
    tick();
    chk("t5_idle_busy", 32'(a_if.busy), 32'h0);
    chk("t5_idle_gnt",  32'(a_if.gnt),  32'h0);
    tick();
    chk("t5_next_busy", 32'(a_if.busy), 32'h1);
    chk("t5_next_sel0", 32'(a_if.sel),  32'h0);
    wait_busy_a(1'b0);
    idle_gap();

    // Asynchronous reset in the middle of a stalled burst.
    lane_a[2] = 8'h70; adv_a = 4'b0100; a_if.req = 4'b0100; a_if.out_ready = 1'b0; drive();
    wait_busy_a(1'b1);
    chk("t6_sel_2", 32'(a_if.sel), 32'h2);
    tick();
    chk("t6_inflight_valid", 32'(a_if.out_valid), 32'h1);
    chk("t6_inflight_data",  32'(a_if.out_data),  32'h70);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(a_if.out_valid), 32'h0);
    chk("t6_rst_data",  32'(a_if.out_data),  32'h0);
    chk("t6_rst_gnt",   32'(a_if.gnt),       32'h0);
    chk("t6_rst_busy",  32'(a_if.busy),      32'h0);
    chk("t6_rst_sel",   32'(a_if.sel),       32'h0);
    lane_a[1] = 8'h60; adv_a = 4'b0000; a_if.req = 4'b0110; a_if.out_ready = 1'b1; drive();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_busy_a(1'b1);
    chk("t6_after_rst_sel", 32'(a_if.sel), 32'h1);
    a_if.req = 4'b0000; drive();
    wait_busy_a(1'b0);
    idle_gap();

    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
